// File: rtl/pixel_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : pixel_port_arbiter
// Purpose  : Round-robin owner of the shared VGA plot port and collision RAM,
//            with read-check-write player transactions and a full-screen clear.
// Revision : 1.0  initial release
// ============================================================================
module pixel_port_arbiter #(
    parameter int          SCR_W     = 160,
    parameter int          SCR_H     = 120,
    parameter int          RAM_LAT   = 1,
    parameter logic [2:0]  BG_COLOUR = 3'b000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req,
    input  logic [7:0]  req_x0,
    input  logic [7:0]  req_x1,
    input  logic [7:0]  req_y0,
    input  logic [7:0]  req_y1,
    input  logic [2:0]  req_c0,
    input  logic [2:0]  req_c1,
    input  logic        clear_req,
    output logic [1:0]  ack,
    output logic        hit,
    output logic        busy,
    output logic        clear_done,
    output logic [7:0]  vga_x,
    output logic [7:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,
    output logic [15:0] ram_addr,
    output logic [2:0]  ram_data,
    output logic        ram_rden,
    output logic        ram_wren,
    input  logic [2:0]  ram_q
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RD    = 3'd1,
        S_WAITQ = 3'd2,
        S_WR    = 3'd3,
        S_ACK   = 3'd4,
        S_CLEAR = 3'd5
    } state_t;

    localparam int              c_WW        = (RAM_LAT > 1) ? $clog2(RAM_LAT) : 1;
    localparam logic [c_WW-1:0] c_WAIT_LAST = c_WW'(RAM_LAT - 1);
    localparam logic [8:0]      c_W         = 9'(SCR_W);
    localparam logic [8:0]      c_H         = 9'(SCR_H);
    localparam logic [7:0]      c_X_LAST    = 8'(SCR_W - 1);
    localparam logic [7:0]      c_Y_LAST    = 8'(SCR_H - 1);

    state_t          r_state, w_next;
    logic [7:0]      r_x, r_y;
    logic [2:0]      r_c;
    logic            r_id, r_hit, r_rr, r_pend, r_clear_done;
    logic [c_WW-1:0] r_wait;

    logic            w_gid, w_oor, w_clr_go, w_clr_last, w_wait_last;
    logic [7:0]      w_gx, w_gy;
    logic [2:0]      w_gc;

    // The pointed-to player wins when it requests; otherwise the other one.
    assign w_gid       = req[r_rr] ? r_rr : ~r_rr;
    assign w_gx        = w_gid ? req_x1 : req_x0;
    assign w_gy        = w_gid ? req_y1 : req_y0;
    assign w_gc        = w_gid ? req_c1 : req_c0;
    assign w_oor       = ({1'b0, w_gx} >= c_W) || ({1'b0, w_gy} >= c_H);
    assign w_clr_go    = r_pend || clear_req;
    assign w_clr_last  = (r_x == c_X_LAST) && (r_y == c_Y_LAST);
    assign w_wait_last = (r_wait == c_WAIT_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_x          <= '0;
            r_y          <= '0;
            r_c          <= '0;
            r_id         <= 1'b0;
            r_hit        <= 1'b0;
            r_rr         <= 1'b0;
            r_pend       <= 1'b0;
            r_clear_done <= 1'b0;
            r_wait       <= '0;
        end else begin
            r_clear_done <= (r_state == S_CLEAR) && w_clr_last;
            if (w_next == S_CLEAR && r_state != S_CLEAR) begin
                r_pend <= 1'b0;
            end else if (clear_req && r_state != S_CLEAR) begin
                r_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_clr_go) begin
                        r_x <= '0;
                        r_y <= '0;
                    end else if (|req) begin
                        r_x   <= w_gx;
                        r_y   <= w_gy;
                        r_c   <= w_gc;
                        r_id  <= w_gid;
                        r_rr  <= ~w_gid;
                        r_hit <= w_oor;
                    end
                end
                S_WAITQ: begin
                    if (w_wait_last) begin
                        r_wait <= '0;
                        r_hit  <= (ram_q != 3'b000);
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_CLEAR: begin
                    if (r_x == c_X_LAST) begin
                        r_x <= '0;
                        r_y <= r_y + 1'b1;
                    end else begin
                        r_x <= r_x + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next     = r_state;
        ack        = 2'b00;
        hit        = 1'b0;
        busy       = (r_state != S_IDLE);
        clear_done = r_clear_done;
        vga_x      = '0;
        vga_y      = '0;
        vga_colour = '0;
        vga_plot   = 1'b0;
        ram_addr   = '0;
        ram_data   = '0;
        ram_rden   = 1'b0;
        ram_wren   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_clr_go) begin
                    w_next = S_CLEAR;
                end else if (|req) begin
                    w_next = w_oor ? S_ACK : S_RD;
                end
            end
            S_RD: begin
                ram_addr = {r_x, r_y};
                ram_rden = 1'b1;
                w_next   = S_WAITQ;
            end
            S_WAITQ: begin
                if (w_wait_last) begin
                    w_next = S_WR;
                end
            end
            S_WR: begin
                ram_addr   = {r_x, r_y};
                ram_data   = r_c;
                ram_wren   = 1'b1;
                vga_x      = r_x;
                vga_y      = r_y;
                vga_colour = r_c;
                vga_plot   = 1'b1;
                w_next     = S_ACK;
            end
            S_ACK: begin
                ack    = r_id ? 2'b10 : 2'b01;
                hit    = r_hit;
                w_next = S_IDLE;
            end
            S_CLEAR: begin
                ram_addr   = {r_x, r_y};
                ram_data   = BG_COLOUR;
                ram_wren   = 1'b1;
                vga_x      = r_x;
                vga_y      = r_y;
                vga_colour = BG_COLOUR;
                vga_plot   = 1'b1;
                if (w_clr_last) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

endmodule
`default_nettype wire
